wb_trace_checker: RTL and testbench

WB_TRACE_CHECKER -- requirements
Module: wb_trace_checker

---
 rtl/wb_trace_checker.sv | 146 ++++++++++++++
 tb/tb_wb_trace_checker.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_trace_checker.sv
// Writeback trace checker: compares a core's register writebacks
// against a programmed table of expected (register, value) pairs.
module wb_trace_checker #(
    parameter int          DATA_W  = 32,
    parameter int          REG_AW  = 5,
    parameter int          DEPTH   = 16,
    parameter int unsigned TIMEOUT = 1024,
    parameter bit          SKIP_R0 = 1'b1,
    localparam int         IW      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              exp_we,
    input  logic [IW-1:0]     exp_addr,
    input  logic [REG_AW-1:0] exp_reg,
    input  logic [DATA_W-1:0] exp_data,
    input  logic [IW:0]       exp_count,
    input  logic              regwrite,
    input  logic [REG_AW-1:0] writereg,
    input  logic [DATA_W-1:0] writedata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [1:0]        fail_code,
    output logic [IW-1:0]     mismatch_idx,
    output logic [REG_AW-1:0] got_reg,
    output logic [DATA_W-1:0] got_data,
    output logic [IW:0]       events_seen,
    output logic [31:0]       cycle_count
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PASS,
        FAIL
    } state_t;

    localparam logic [IW:0] ONE_E   = (IW+1)'(1);
    localparam logic [IW:0] DEPTH_E = (IW+1)'(DEPTH);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);
    localparam logic [31:0] TO_MAX  = 32'(TIMEOUT);

    state_t            state;
    logic [IW:0]       cnt_q;
    logic [REG_AW-1:0] tbl_reg  [DEPTH];
    logic [DATA_W-1:0] tbl_data [DEPTH];

    logic          qual;
    logic          hit;
    logic          timed_out;
    logic [IW:0]   es_inc;
    logic [IW-1:0] idx;

    assign idx       = events_seen[IW-1:0];
    assign qual      = regwrite &&
                       !(SKIP_R0 && writereg == '0);
    assign hit       = tbl_reg[idx] == writereg &&
                       tbl_data[idx] == writedata;
    assign timed_out = cycle_count == TO_LAST;
    assign es_inc    = events_seen + ONE_E;

    // Expectation table: frozen while a run is active, kept over reset.
    always_ff @(posedge clk) begin
        if (exp_we && state != RUN) begin
            tbl_reg[exp_addr]  <= exp_reg;
            tbl_data[exp_addr] <= exp_data;
        end
    end

    // Run control, counters and first-failure capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt_q        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            fail_code    <= 2'd0;
            mismatch_idx <= '0;
            got_reg      <= '0;
            got_data     <= '0;
            events_seen  <= '0;
            cycle_count  <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (cycle_count != TO_MAX)
                        cycle_count <= cycle_count + 32'd1;
                    if (cnt_q == '0) begin
                        state <= PASS;
                        pass  <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (qual && hit) begin
                        events_seen <= es_inc;
                        if (es_inc == cnt_q) begin
                            state <= PASS;
                            pass  <= 1'b1;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else if (timed_out) begin
                            state       <= FAIL;
                            fail_code   <= 2'd2;
                            done        <= 1'b1;
                            busy        <= 1'b0;
                            cycle_count <= cycle_count;
                        end
                    end else if (qual) begin
                        state        <= FAIL;
                        fail_code    <= 2'd1;
                        mismatch_idx <= idx;
                        got_reg      <= writereg;
                        got_data     <= writedata;
                        done         <= 1'b1;
                        busy         <= 1'b0;
                    end else if (timed_out) begin
                        state       <= FAIL;
                        fail_code   <= 2'd2;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        cycle_count <= cycle_count;
                    end
                end
                default: begin
                    if (start) begin
                        state        <= RUN;
                        cnt_q        <= (exp_count > DEPTH_E) ?
                                        DEPTH_E : exp_count;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        pass         <= 1'b0;
                        fail_code    <= 2'd0;
                        mismatch_idx <= '0;
                        got_reg      <= '0;
                        got_data     <= '0;
                        events_seen  <= '0;
                        cycle_count  <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_trace_checker.sv
// Randomised bench for wb_trace_checker with a run-level
// reference model and the directed scenarios.
module tb_wb_trace_checker;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int DP  = 16;
    localparam int IW  = 4;
    localparam int TO  = 16;
    localparam int NS  = 40;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          exp_we = 1'b0;
    logic [IW-1:0] exp_addr = '0;
    logic [AW-1:0] exp_reg = '0;
    logic [DW-1:0] exp_data = '0;
    logic [IW:0]   exp_count = '0;
    logic          regwrite = 1'b0;
    logic [AW-1:0] writereg = '0;
    logic [DW-1:0] writedata = '0;
    logic          busy, done, pass;
    logic [1:0]    fail_code;
    logic [IW-1:0] mismatch_idx;
    logic [AW-1:0] got_reg;
    logic [DW-1:0] got_data;
    logic [IW:0]   events_seen;
    logic [31:0]   cycle_count;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] m_reg [DP];
    logic [DW-1:0] m_dat [DP];

    logic          s_we  [NS];
    logic [AW-1:0] s_reg [NS];
    logic [DW-1:0] s_dat [NS];
    logic          s_st  [NS];
    logic          s_tw  [NS];

    wb_trace_checker #(
        .DATA_W(DW), .REG_AW(AW), .DEPTH(DP),
        .TIMEOUT(TO), .SKIP_R0(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .exp_we(exp_we), .exp_addr(exp_addr),
        .exp_reg(exp_reg), .exp_data(exp_data),
        .exp_count(exp_count), .regwrite(regwrite),
        .writereg(writereg), .writedata(writedata),
        .busy(busy), .done(done), .pass(pass),
        .fail_code(fail_code),
        .mismatch_idx(mismatch_idx),
        .got_reg(got_reg), .got_data(got_data),
        .events_seen(events_seen),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h",
                     tag, got, exp);
        end
    endtask

    task automatic load(input int a, input int r,
                        input logic [DW-1:0] d);
        @(negedge clk);
        exp_we   = 1'b1;
        exp_addr = IW'(a);
        exp_reg  = AW'(r);
        exp_data = d;
        m_reg[a] = AW'(r);
        m_dat[a] = d;
        @(negedge clk);
        exp_we = 1'b0;
    endtask

    task automatic clear_stim();
        for (int k = 0; k < NS; k++) begin
            s_we[k]  = 1'b0;
            s_reg[k] = AW'($urandom);
            s_dat[k] = $urandom;
            s_st[k]  = 1'b0;
            s_tw[k]  = 1'b0;
        end
    endtask

    task automatic put(input int k, input int r,
                       input logic [DW-1:0] d);
        s_we[k]  = 1'b1;
        s_reg[k] = AW'(r);
        s_dat[k] = d;
    endtask

    // Random writeback stream aimed at the table entries in order.
    task automatic gen_random(input bit mis);
        int p;
        int r;
        p = 0;
        clear_stim();
        for (int k = 0; k < NS; k++) begin
            r = $urandom_range(0, 9);
            s_st[k] = ($urandom_range(0, 7) == 0);
            s_tw[k] = ($urandom_range(0, 3) == 0);
            if (r == 3) begin
                put(k, 0, $urandom);
            end else if (r == 4 && mis) begin
                put(k, int'(m_reg[p % DP]),
                    m_dat[p % DP] ^ 32'h1);
            end else if (r >= 5) begin
                put(k, int'(m_reg[p % DP]), m_dat[p % DP]);
                p++;
            end
        end
    endtask

    // Outcome of a whole run from the stimulus, cycle k = k-th RUN cycle.
    task automatic model(input int cnt,
                         output int e_kx, output bit e_pass,
                         output int e_fc, output int e_es,
                         output int e_idx, output int e_reg,
                         output logic [DW-1:0] e_dat,
                         output int e_cc);
        int  n;
        bit  q;
        n = (cnt > DP) ? DP : cnt;
        e_kx = -1; e_pass = 0; e_fc = 0; e_es = 0;
        e_idx = 0; e_reg = 0; e_dat = '0; e_cc = 0;
        for (int k = 0; k < NS; k++) begin
            q = s_we[k] && s_reg[k] != 0;
            if (n == 0) begin
                e_pass = 1; e_cc = k + 1; e_kx = k;
                return;
            end
            if (q && s_reg[k] == m_reg[e_es] &&
                s_dat[k] == m_dat[e_es]) begin
                e_es++;
                if (e_es == n) begin
                    e_pass = 1; e_cc = k + 1; e_kx = k;
                    return;
                end
                if (k == TO - 1) begin
                    e_fc = 2; e_cc = k; e_kx = k;
                    return;
                end
            end else if (q) begin
                e_fc = 1; e_idx = e_es;
                e_reg = int'(s_reg[k]); e_dat = s_dat[k];
                e_cc = k + 1; e_kx = k;
                return;
            end else if (k == TO - 1) begin
                e_fc = 2; e_cc = k; e_kx = k;
                return;
            end
        end
    endtask

    task automatic idle_in();
        regwrite  = 1'b0;
        writereg  = '0;
        writedata = '0;
        start     = 1'b0;
        exp_we    = 1'b0;
    endtask

    task automatic run_check(input int cnt, input string tag);
        int kx, fc, es, ix, rg, cc, kd;
        bit ps;
        logic [DW-1:0] dt;
        model(cnt, kx, ps, fc, es, ix, rg, dt, cc);
        @(negedge clk);
        exp_count = (IW+1)'(cnt);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, ".busy"}, busy, 1);
        kd = -1;
        for (int k = 0; k < NS; k++) begin
            regwrite  = s_we[k];
            writereg  = s_reg[k];
            writedata = s_dat[k];
            start     = s_st[k];
            exp_we    = s_tw[k];
            exp_addr  = IW'($urandom);
            exp_reg   = AW'($urandom);
            exp_data  = $urandom;
            @(negedge clk);
            if (done) begin
                kd = k;
                break;
            end
        end
        idle_in();
        check({tag, ".exit"}, 64'(kd), 64'(kx));
        check({tag, ".pass"}, pass, 64'(ps));
        check({tag, ".busy0"}, busy, 0);
        check({tag, ".fc"}, fail_code, 64'(fc));
        check({tag, ".es"}, events_seen, 64'(es));
        check({tag, ".cc"}, cycle_count, 64'(cc));
        check({tag, ".idx"}, mismatch_idx, 64'(ix));
        check({tag, ".greg"}, got_reg, 64'(rg));
        check({tag, ".gdat"}, got_data, 64'(dt));
        for (int h = 0; h < 3; h++) begin
            regwrite  = 1'b1;
            writereg  = AW'($urandom_range(1, 31));
            writedata = $urandom;
            @(negedge clk);
        end
        idle_in();
        check({tag, ".hold_es"}, events_seen, 64'(es));
        check({tag, ".hold_cc"}, cycle_count, 64'(cc));
        check({tag, ".hold_done"}, done, 1);
    endtask

    task automatic chk_zero(input string tag);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".done"}, done, 0);
        check({tag, ".pass"}, pass, 0);
        check({tag, ".fc"}, fail_code, 0);
        check({tag, ".idx"}, mismatch_idx, 0);
        check({tag, ".greg"}, got_reg, 0);
        check({tag, ".gdat"}, got_data, 0);
        check({tag, ".es"}, events_seen, 0);
        check({tag, ".cc"}, cycle_count, 0);
    endtask

    task automatic scen1_stim();
        clear_stim();
        put(1, 8, 32'd5);
        put(4, 9, 32'd7);
        put(6, 10, 32'd12);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_zero("rst");
        reset = 1'b0;
        for (int i = 0; i < DP; i++)
            load(i, $urandom_range(1, 31), $urandom);
        load(0, 8, 32'd5);
        load(1, 9, 32'd7);
        load(2, 10, 32'd12);

        scen1_stim();
        run_check(3, "s1");
        check("s1.p", pass, 1);
        check("s1.e", events_seen, 3);

        clear_stim();
        put(1, 8, 32'd5);
        put(3, 9, 32'd8);
        run_check(3, "s2");
        check("s2.fc", fail_code, 1);
        check("s2.idx", mismatch_idx, 1);
        check("s2.reg", got_reg, 9);
        check("s2.dat", got_data, 8);

        clear_stim();
        put(0, 0, 32'hDEAD);
        put(1, 8, 32'd5);
        put(2, 0, 32'hDEAD);
        put(3, 9, 32'd7);
        put(4, 0, 32'hDEAD);
        put(5, 10, 32'd12);
        run_check(3, "s3");
        check("s3.p", pass, 1);
        check("s3.e", events_seen, 3);

        clear_stim();
        put(2, 8, 32'd5);
        put(5, 9, 32'd7);
        run_check(3, "s4");
        check("s4.fc", fail_code, 2);
        check("s4.e", events_seen, 2);
        check("s4.cc", cycle_count, 15);

        @(negedge clk);
        exp_count = 5'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        regwrite = 1'b1;
        writereg = 5'd8;
        writedata = 32'd5;
        @(negedge clk);
        idle_in();
        check("s5.es1", events_seen, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_zero("s5");
        scen1_stim();
        run_check(3, "s5r");
        check("s5r.p", pass, 1);

        clear_stim();
        s_st[0] = 1'b1;
        run_check(0, "s6");
        check("s6.p", pass, 1);

        for (int r = 0; r < 14; r++) begin
            gen_random($urandom_range(0, 2) == 0);
            run_check($urandom_range(0, 6),
                      $sformatf("rnd%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
